// File: rtl/tw_mul_goldilocks_2lane.sv
// rtl/tw_mul_goldilocks_2lane.sv - two-lane 4-stage modular multiplier over p = 2^64 - 2^32 + 1
// Twiddle ROM output times butterfly data, canonical result with frame tagging.
module tw_mul_goldilocks_2lane #(
    parameter int DW        = 64,
    parameter int P_WIDTH   = 128,
    parameter int FRAME_LEN = 16,
    parameter int FC_WIDTH  = 4
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [P_WIDTH-1:0]  data_in,
    input  logic [P_WIDTH-1:0]  tw_in,
    input  logic [P_WIDTH-1:0]  const_in,
    input  logic                tw_sel,
    output logic                out_valid,
    output logic [P_WIDTH-1:0]  data_out,
    output logic                out_last,
    output logic [FC_WIDTH-1:0] frame_cnt
);

    localparam logic [DW-1:0]       P_MOD   = 64'hFFFF_FFFF_0000_0001;
    localparam logic [DW-1:0]       EPS     = 64'h0000_0000_FFFF_FFFF;
    localparam logic [FC_WIDTH-1:0] FC_LAST = FC_WIDTH'(FRAME_LEN - 1);

    // 2^64 = 2^32 - 1 and 2^96 = -1 (mod p): fold the top word in by subtraction
    function automatic logic [DW-1:0] fold_hi(input logic [2*DW-1:0] x);
        logic [DW-1:0] lo;
        logic [DW-1:0] hh;
        logic [DW-1:0] t0;
        lo = x[DW-1:0];
        hh = {32'd0, x[2*DW-1:96]};
        t0 = lo - hh;
        if (lo < hh) begin
            t0 = t0 - EPS;
        end
        return t0;
    endfunction

    function automatic logic [DW-1:0] fold_mid(input logic [DW-1:0] t0, input logic [31:0] hl);
        logic [DW-1:0] m;
        logic [DW:0]   sum;
        logic [DW-1:0] r;
        m   = {hl, 32'd0} - {32'd0, hl};
        sum = {1'b0, t0} + {1'b0, m};
        r   = sum[DW-1:0];
        if (sum[DW]) begin
            r = r + EPS;
        end
        if (r >= P_MOD) begin
            r = r - P_MOD;
        end
        return r;
    endfunction

    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic [1:0][DW-1:0]      a1_q, a1_d, t1_q, t1_d;
    logic [1:0][2*DW-1:0]    x2_q, x2_d;
    logic [1:0][DW-1:0]      r3_q, r3_d;
    logic [1:0][31:0]        hl3_q, hl3_d;
    logic [P_WIDTH-1:0]      dout_q, dout_d;
    logic [FC_WIDTH-1:0]     fc_q, fc_d;

    always_comb begin
        v1_d  = in_valid & ~clr;
        v2_d  = v1_q & ~clr;
        v3_d  = v2_q & ~clr;
        v4_d  = v3_q & ~clr;
        a1_d  = a1_q;
        t1_d  = t1_q;
        x2_d  = x2_q;
        r3_d  = r3_q;
        hl3_d = hl3_q;
        dout_d = dout_q;
        if (in_valid) begin
            a1_d = data_in;
            t1_d = tw_sel ? const_in : tw_in;
        end
        for (int l = 0; l < 2; l++) begin
            if (v1_q) begin
                x2_d[l] = {64'd0, a1_q[l]} * {64'd0, t1_q[l]};
            end
            if (v2_q) begin
                r3_d[l]  = fold_hi(x2_q[l]);
                hl3_d[l] = x2_q[l][95:64];
            end
        end
        // data_out only moves on surviving beats so it holds across bubbles and clr
        if (v3_q && !clr) begin
            dout_d = {fold_mid(r3_q[1], hl3_q[1]), fold_mid(r3_q[0], hl3_q[0])};
        end
        fc_d = fc_q;
        if (clr) begin
            fc_d = '0;
        end else if (v4_q) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            a1_q   <= '0;
            t1_q   <= '0;
            x2_q   <= '0;
            r3_q   <= '0;
            hl3_q  <= '0;
            dout_q <= '0;
            fc_q   <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            v4_q   <= v4_d;
            a1_q   <= a1_d;
            t1_q   <= t1_d;
            x2_q   <= x2_d;
            r3_q   <= r3_d;
            hl3_q  <= hl3_d;
            dout_q <= dout_d;
            fc_q   <= fc_d;
        end
    end

    assign out_valid = v4_q;
    assign data_out  = dout_q;
    assign frame_cnt = fc_q;
    assign out_last  = v4_q && (fc_q == FC_LAST);

endmodule
